code_to_onehot_decoder: RTL

- Registered, handshaked N-to-2^N decoder. It is the receive-side counterpart of the 8x3 encoder and priority-encoder family.
- Consumes a stream of encoded indices, each with a code-valid flag, and produces one-hot words.
- Single mode: one output word per input beat.
- Accumulate mode: ORs the decoded bits of a multi-beat frame into one request mask, rebuilding the original request vector.
- Sits downstream of a priority encoder, e.g. an arbiter grant path or a request-vector transport.

---
 rtl/decoder_pkg.sv | 26 ++
 rtl/onehot_dec.sv | 29 ++
 rtl/code_to_onehot_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//
// Shared definitions for the code-to-one-hot decoder slice.
//   CODE_W_DEFAULT : default width of the encoded index
//   state_t        : frame-level FSM states (IDLE, ACCUM, HOLD)
//   MODE_SINGLE    : one output word per accepted beat
//   MODE_ACCUM     : OR all beats of a frame into a single request mask
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int CODE_W_DEFAULT = 3;

    // IDLE  : waiting for the first beat of a frame
    // ACCUM : inside a multi-beat accumulate frame
    // HOLD  : result word presented on the output, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_ACCUM  = 1'b1;

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//
// Purely combinational N-to-2^N decoder with a "no request" qualifier.
//   code       in  CODE_W  encoded index
//   code_valid in  1       0 forces an all-zero result
//   onehot     out OUT_W   1 << code when code_valid, else 0
// -----------------------------------------------------------------------------
module onehot_dec
    import decoder_pkg::*;
#(
    parameter  int CODE_W = CODE_W_DEFAULT,
    localparam int OUT_W  = 2**CODE_W
) (
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic [OUT_W-1:0]  onehot
);

    // The index is only looked at under code_valid, so an undriven code on a
    // "no request" beat can never leak into the result.
    always_comb begin
        onehot = '0;
        if (code_valid) begin
            onehot[code] = 1'b1;
        end
    end

endmodule : onehot_dec

// File: rtl/code_to_onehot_decoder.sv
// -----------------------------------------------------------------------------
// code_to_onehot_decoder
//
// Registered, handshaked N-to-2^N decoder. In single mode every accepted beat
// yields one one-hot word; in accumulate mode the decoded bits of a frame
// (terminated by in_last) are ORed into one request mask.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en_n           active-low enable, 1 blocks input acceptance
//   mode           0 single / 1 accumulate, sampled on a frame's first beat
//   in_valid/ready input handshake
//   in_code        encoded index
//   in_code_valid  0 = beat contributes no bit
//   in_last        final beat of an accumulate frame
//   out_valid/ready output handshake
//   out_onehot     decoded or accumulated mask
//   out_count      number of set bits in out_onehot
//   out_empty      out_onehot == 0
// -----------------------------------------------------------------------------
module code_to_onehot_decoder
    import decoder_pkg::*;
#(
    parameter  int CODE_W = CODE_W_DEFAULT,
    localparam int OUT_W  = 2**CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_code_valid,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_onehot,
    output logic [CODE_W:0]   out_count,
    output logic              out_empty
);

    state_t             state, state_n;
    logic [OUT_W-1:0]   acc, acc_n;
    logic               mode_q, mode_n;
    logic [OUT_W-1:0]   beat_bits;
    logic [OUT_W-1:0]   result;
    logic               load;
    logic               in_fire;
    logic               out_fire;
    logic               start_frame;

    function automatic logic [CODE_W:0] popcount(input logic [OUT_W-1:0] v);
        logic [CODE_W:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + (CODE_W+1)'(v[i]);
        end
        return c;
    endfunction

    onehot_dec #(
        .CODE_W     (CODE_W)
    ) u_dec (
        .code       (in_code),
        .code_valid (in_code_valid),
        .onehot     (beat_bits)
    );

    // In HOLD a new beat may only be taken when the held word leaves in the
    // same cycle, which is what lets single mode run at one word per clock.
    // rst_n is folded in so nothing is accepted while reset is held.
    assign in_ready  = rst_n && !en_n && ((state != HOLD) || out_ready);
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // A beat accepted in IDLE, or in HOLD alongside the output handshake, is
    // always the first beat of a new frame.
    assign start_frame = in_fire && ((state == IDLE) || (state == HOLD));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        mode_n  = mode_q;
        load    = 1'b0;
        result  = '0;

        if ((state == HOLD) && out_fire) begin
            state_n = IDLE;
        end

        if (start_frame) begin
            mode_n = mode;
            if ((mode == MODE_SINGLE) || in_last) begin
                result  = beat_bits;
                load    = 1'b1;
                state_n = HOLD;
            end else begin
                acc_n   = beat_bits;
                state_n = ACCUM;
            end
        end else if ((state == ACCUM) && in_fire) begin
            // The mode input is ignored mid-frame; the latched mode is
            // always MODE_ACCUM here, the extra term only closes the frame
            // defensively should that ever not hold.
            acc_n = acc | beat_bits;
            if (in_last || (mode_q == MODE_SINGLE)) begin
                result  = acc | beat_bits;
                load    = 1'b1;
                state_n = HOLD;
            end
        end

        if ((state != IDLE) && (state != ACCUM) && (state != HOLD)) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mode_q <= MODE_SINGLE;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mode_q <= mode_n;
        end
    end

    // Output word registers only change when a new word enters HOLD, so they
    // stay stable under backpressure and keep their value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_onehot <= '0;
            out_count  <= '0;
            out_empty  <= 1'b1;
        end else if (load) begin
            out_onehot <= result;
            out_count  <= popcount(result);
            out_empty  <= (result == '0);
        end
    end

endmodule : code_to_onehot_decoder
